// File: rtl/anode_scan_pkg.sv
// rtl/anode_scan_pkg.sv - shared types and width helpers for the anode scanner
//
// Purpose: scan FSM state encoding, constant-width helpers, and the brightness
//          on-time function shared by the scanner top and its interface.
// Ports:   none (package).
// Config:  on_cycles() is only needed when ANODE_BRIGHTNESS_EN is defined, but it
//          is always compiled so the default build reuses it with bright = 15.
package anode_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  // Bits needed to hold values 0..value-1 (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Shared BLANK/DRIVE down-counter width; never narrower than one bit.
  function automatic int timer_width(input int dwell, input int blank);
    return max2(1, clog2(max2(dwell, blank)));
  endfunction

  // digit_sel width; a single-bit select is kept even for tiny scans.
  function automatic int sel_width(input int num_digits);
    return max2(1, clog2(num_digits));
  endfunction

  // Cycles of the dwell during which the anode may be low.
  function automatic int on_cycles(input logic [3:0] bright, input int dwell);
    int v;
    v = (({28'd0, bright} + 1) * dwell) >> 4;
    return (v < 1) ? 1 : v;
  endfunction

  localparam int DEFAULT_DWELL_CYCLES = 16;
  localparam int DEFAULT_BLANK_CYCLES = 2;
  localparam int TIMER_W = timer_width(DEFAULT_DWELL_CYCLES, DEFAULT_BLANK_CYCLES);

endpackage

// File: rtl/anode_scan_driver_if.sv
// rtl/anode_scan_driver_if.sv - control/status bundle between formatter and anode scanner
//
// Purpose: groups the scanner's control inputs and display outputs.
// Signals: enable       - 1 = scan, 0 = all anodes off
//          digit_mask   - per-digit light permission
//          bright       - 4-bit brightness (only with ANODE_BRIGHTNESS_EN)
//          an           - active-low anodes
//          digit_sel    - current slot index
//          frame_start  - pulse at the start of each digit-0 slot
// Modports: master = formatter side, slave = scanner side.
interface anode_scan_driver_if
  import anode_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  localparam int SEL_W = sel_width(NUM_DIGITS);

  logic                  enable;
  logic [NUM_DIGITS-1:0] digit_mask;
`ifdef ANODE_BRIGHTNESS_EN
  logic [3:0]            bright;
`endif
  logic [NUM_DIGITS-1:0] an;
  logic [SEL_W-1:0]      digit_sel;
  logic                  frame_start;

`ifdef ANODE_BRIGHTNESS_EN
  modport master (output enable, digit_mask, bright, input an, digit_sel, frame_start);
  modport slave  (input enable, digit_mask, bright, output an, digit_sel, frame_start);
`else
  modport master (output enable, digit_mask, input an, digit_sel, frame_start);
  modport slave  (input enable, digit_mask, output an, digit_sel, frame_start);
`endif

endinterface

// File: rtl/anode_scan_driver_scan_timer.sv
// rtl/anode_scan_driver_scan_timer.sv - loadable down-counter with zero flag
//
// Purpose: shared BLANK/DRIVE timer. load takes priority over dec; dec stops at 0.
// Ports:   clk, reset      - clock, synchronous active-high reset (count -> 0)
//          load/load_value - parallel load
//          dec             - decrement by one
//          count           - registered count
//          count_next      - value count will take on the next edge
//          zero            - count == 0
module scan_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next,
  output logic             zero
);

  always_comb begin
    count_next = count;
    if (load) begin
      count_next = load_value;
    end else if (dec && (count != '0)) begin
      count_next = count - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/anode_scan_driver.sv
// rtl/anode_scan_driver.sv - multiplexed 7-segment anode scanner
//
// Purpose: scans NUM_DIGITS active-low anodes in index order with a programmable
//          dwell, optional blanking dead-time before each digit, and a per-digit mask.
// Ports:   clk    - system clock, rising edge
//          reset  - synchronous, active-high
//          bus    - anode_scan_driver_if.slave: enable, digit_mask, [bright] in;
//                   an, digit_sel, frame_start out (all outputs registered)
// Config:  ANODE_BRIGHTNESS_EN adds bus.bright; the anode is then low only for the
//          first on_cycles(bright) cycles of each dwell. Without it the full dwell lights.
module anode_scan_driver
  import anode_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = DEFAULT_DWELL_CYCLES,
  parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  anode_scan_driver_if.slave bus
);

  localparam int SEL_W = sel_width(NUM_DIGITS);
  localparam int TW    = timer_width(DWELL_CYCLES, BLANK_CYCLES);

  localparam logic [TW-1:0]    DWELL_LOAD = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0]    BLANK_LOAD = TW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(NUM_DIGITS - 1);

  scan_state_t           state, state_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fs_q, fs_d;

  logic                  load, dec;
  logic [TW-1:0]         load_value;
  logic [TW-1:0]         timer, timer_next;
  logic                  timer_zero;

  logic [3:0]            bright_eff;
  logic                  lit;
  int                    elapsed;

  scan_timer #(.WIDTH(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .dec        (dec),
    .count      (timer),
    .count_next (timer_next),
    .zero       (timer_zero)
  );

  // Next-state, slot index and timer control.
  always_comb begin
    state_d    = state;
    sel_d      = sel_q;
    fs_d       = 1'b0;
    load       = 1'b0;
    load_value = '0;
    dec        = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.enable) begin
          sel_d = '0;
          fs_d  = 1'b1;
          load  = 1'b1;
          if (BLANK_CYCLES > 0) begin
            state_d    = BLANK;
            load_value = BLANK_LOAD;
          end else begin
            state_d    = DRIVE;
            load_value = DWELL_LOAD;
          end
        end
      end

      BLANK: begin
        if (!bus.enable) begin
          state_d = IDLE;
          sel_d   = '0;
          load    = 1'b1;
        end else if (timer_zero) begin
          state_d    = DRIVE;
          load       = 1'b1;
          load_value = DWELL_LOAD;
        end else begin
          dec = 1'b1;
        end
      end

      DRIVE: begin
        if (!bus.enable) begin
          state_d = IDLE;
          sel_d   = '0;
          load    = 1'b1;
        end else if (timer_zero) begin
          sel_d = (sel_q == LAST_SEL) ? '0 : sel_q + SEL_W'(1);
          // Only the wrap lands on index 0, so this marks the next frame.
          fs_d  = (sel_d == '0);
          load  = 1'b1;
          if (BLANK_CYCLES > 0) begin
            state_d    = BLANK;
            load_value = BLANK_LOAD;
          end else begin
            load_value = DWELL_LOAD;
          end
        end else begin
          dec = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        sel_d   = '0;
        load    = 1'b1;
      end
    endcase
  end

`ifdef ANODE_BRIGHTNESS_EN
  // Brightness is latched when a dwell begins so a slot never changes duty midway.
  logic [3:0] bright_q;
  logic       drive_entry;

  assign drive_entry = (state_d == DRIVE) && ((state != DRIVE) || timer_zero);
  assign bright_eff  = drive_entry ? bus.bright : bright_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bright_q <= 4'd0;
    end else if (drive_entry) begin
      bright_q <= bus.bright;
    end
  end
`else
  assign bright_eff = 4'hF;
`endif

  // Anode decode from the next state so an/digit_sel move on the same edge as state.
  // The dwell position comes from the timer value being loaded on that edge.
  always_comb begin
    elapsed = (DWELL_CYCLES - 1) - int'(timer_next);
    lit     = (elapsed < on_cycles(bright_eff, DWELL_CYCLES));
    an_d    = '1;
    if ((state_d == DRIVE) && lit) begin
      an_d[sel_d] = ~bus.digit_mask[sel_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sel_q <= '0;
      an_q  <= '1;
      fs_q  <= 1'b0;
    end else begin
      state <= state_d;
      sel_q <= sel_d;
      an_q  <= an_d;
      fs_q  <= fs_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.digit_sel   = sel_q;
  assign bus.frame_start = fs_q;

endmodule
